uart_msg_sequencer: RTL and testbench
=====================================

UART_MSG_SEQUENCER -- requirements
Module: uart_msg_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, message-memory address width.
REQ-003 SHALL have parameter GAP_CYCLES, default 38399, enabled-cycle count between repeat passes.
REQ-004 SHALL have port Clk  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port Enable  input  1  clock enable; when low, all registers hold.
REQ-007 SHALL have port Start  input  1  begin a message; sampled in IDLE only.
REQ-008 SHALL have port Abort  input  1  terminate the current message.
REQ-009 SHALL have port Mode  input  1  0 = one-shot, 1 = repeat; latched at Start.
REQ-010 SHALL have port MsgBase  input  ADDR_W  first character address; latched at Start.
REQ-011 SHALL have port MsgLen  input  ADDR_W  character count; latched at Start.
REQ-012 SHALL have port TxEmpty  input  1  transmitter ready for a character.
REQ-013 SHALL have port RdData  input  DATA_W  memory data, valid one enabled cycle after RdAddr.
REQ-014 SHALL have port RdAddr  output  ADDR_W  registered memory address.
REQ-015 SHALL have port XMitGo  output  1  registered one-cycle load strobe to the transmitter.
REQ-016 SHALL have port TxData  output  DATA_W  registered character, stable while XMitGo is high.
REQ-017 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port Done  output  1  registered one-cycle pulse at the end of each completed pass.

Function
REQ-019 SHALL implement states IDLE, FETCH, WAIT_EMPTY, SEND and GAP; all transitions occur only on enabled cycles.
REQ-020 In IDLE, Start=1 with MsgLen!=0 SHALL latch MsgBase, MsgLen and Mode, load RdAddr<=MsgBase and Count<=0, and enter FETCH.
REQ-021 In IDLE, Start=1 with MsgLen==0 SHALL pulse Done, send no character, and remain in IDLE.
REQ-022 FETCH SHALL last exactly one enabled cycle and then enter WAIT_EMPTY.
REQ-023 WAIT_EMPTY SHALL hold while TxEmpty=0; on TxEmpty=1 it SHALL load TxData<=RdData, set XMitGo<=1, and enter SEND.
REQ-024 SEND SHALL clear XMitGo, increment Count, and increment RdAddr modulo 2^ADDR_W (wrap from max to 0 is legal).
REQ-025 From SEND, when Count+1 != latched length, the block SHALL enter FETCH.
REQ-026 From SEND, on the last character with Mode=0, the block SHALL pulse Done and enter IDLE.
REQ-027 From SEND, on the last character with Mode=1, the block SHALL pulse Done, clear the gap counter, and enter GAP.
REQ-028 GAP SHALL count enabled cycles 0..GAP_CYCLES, then reload RdAddr<=latched base and Count<=0 and enter FETCH; the gap therefore lasts GAP_CYCLES+1 enabled cycles.
REQ-029 XMitGo SHALL be high for exactly one enabled cycle per character, with at least 3 enabled cycles between strobes; the attached transmitter deasserts TxEmpty within 1 cycle of XMitGo.
REQ-030 Start SHALL be ignored outside IDLE; changes to Mode, MsgBase and MsgLen after Start SHALL have no effect on the message in progress.
REQ-031 Abort=1 in any state SHALL return the block to IDLE on the next enabled cycle with XMitGo=0 and no Done pulse; Abort has priority over Start.
REQ-032 Count SHALL be ADDR_W bits wide; the gap counter SHALL be $clog2(GAP_CYCLES+1) bits wide, minimum 1 bit.

Reset
REQ-033 Reset SHALL take priority over Abort, Start and Enable; it acts on the next rising edge even when Enable=0.
REQ-034 Reset SHALL force state IDLE, RdAddr=0, TxData=0, XMitGo=0, Done=0, Busy=0, Count=0, gap counter=0 and all latched inputs to 0.
REQ-035 Reset asserted mid-message SHALL cause no further XMitGo or Done until a new Start.

Verification
REQ-036 One-shot: MsgBase=0x10, MsgLen=3, Mode=0, TxEmpty=1 -> exactly 3 XMitGo strobes with TxData=mem[0x10..0x12], then Done once, then Busy=0.
REQ-037 Back-pressure: hold TxEmpty=0 for 20 cycles after FETCH -> XMitGo stays 0 until TxEmpty rises, and TxData matches the correct address.
REQ-038 Repeat with GAP_CYCLES=5, MsgLen=2, Mode=1 -> Done, then 6 enabled gap cycles, then the first character resent from MsgBase; Done pulses every pass.
REQ-039 Wrap: ADDR_W=8, MsgBase=0xFE, MsgLen=4 -> RdAddr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-040 Abort after 2nd XMitGo of MsgLen=8 -> IDLE next cycle, no Done; a Start in the same cycle is ignored.
REQ-041 Enable toggling 1:3 and Reset mid-GAP -> timing scales by enabled cycles only; after reset all outputs are 0 and the block is in IDLE.

Source files
------------

// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer
// Walks a character message held in an external synchronous-read memory
// and hands it one character at a time to a UART transmitter. A message
// is sent once (one-shot) or over and over with an idle gap between passes
// (repeat).
//
// Ports
//   Clk, Reset      rising-edge clock, synchronous active-high reset
//   Enable          clock enable; every register holds while low
//   Start, Abort    begin a message (IDLE only) / drop back to IDLE
//   Mode            0 = one-shot, 1 = repeat (latched at Start)
//   MsgBase, MsgLen first address and character count (latched at Start)
//   TxEmpty         transmitter can accept a character
//   RdData          memory data, valid one enabled cycle after RdAddr
//   RdAddr          registered memory address
//   XMitGo          one-enabled-cycle load strobe, TxData valid with it
//   TxData          registered character
//   Busy            high in every state except IDLE
//   Done            one-enabled-cycle pulse at the end of each pass
module uart_msg_sequencer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 38399
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] MsgBase,
    input  logic [ADDR_W-1:0] MsgLen,
    input  logic              TxEmpty,
    input  logic [DATA_W-1:0] RdData,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              XMitGo,
    output logic [DATA_W-1:0] TxData,
    output logic              Busy,
    output logic              Done
);

    // $clog2(1) is 0, so a zero-length gap still gets a 1-bit counter.
    localparam int               GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_WAIT_EMPTY = 3'd2;
    localparam logic [2:0] S_SEND       = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic [DATA_W-1:0] txdata_q, txdata_d;
    logic              xmitgo_q, xmitgo_d;
    logic              done_q,   done_d;
    logic [ADDR_W-1:0] count_q,  count_d;
    logic [GAP_W-1:0]  gap_q,    gap_d;
    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W-1:0] len_q,    len_d;
    logic              mode_q,   mode_d;

    logic [ADDR_W-1:0] count_inc;

    assign count_inc = count_q + ADDR_W'(1);

    always_comb begin
        state_d  = state_q;
        rdaddr_d = rdaddr_q;
        txdata_d = txdata_q;
        xmitgo_d = 1'b0;            // strobe lives for a single enabled cycle
        done_d   = 1'b0;            // likewise for the end-of-pass pulse
        count_d  = count_q;
        gap_d    = gap_q;
        base_d   = base_q;
        len_d    = len_q;
        mode_d   = mode_q;

        if (Abort) begin
            // Abort wins over Start and kills any strobe or pulse in flight.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (MsgLen != '0) begin
                            base_d   = MsgBase;
                            len_d    = MsgLen;
                            mode_d   = Mode;
                            rdaddr_d = MsgBase;
                            count_d  = '0;
                            state_d  = S_FETCH;
                        end else begin
                            // Empty message: report completion, send nothing.
                            done_d = 1'b1;
                        end
                    end
                end
                // One cycle for the memory to turn RdAddr into RdData.
                S_FETCH: state_d = S_WAIT_EMPTY;
                S_WAIT_EMPTY: begin
                    if (TxEmpty) begin
                        txdata_d = RdData;
                        xmitgo_d = 1'b1;
                        state_d  = S_SEND;
                    end
                end
                S_SEND: begin
                    count_d  = count_inc;
                    rdaddr_d = rdaddr_q + ADDR_W'(1);   // wraps naturally
                    if (count_inc != len_q) begin
                        state_d = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    // Counts 0..GAP_CYCLES inclusive, i.e. GAP_CYCLES+1 cycles.
                    if (gap_q == GAP_LAST) begin
                        rdaddr_d = base_q;
                        count_d  = '0;
                        state_d  = S_FETCH;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            rdaddr_q <= '0;
            txdata_q <= '0;
            xmitgo_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            gap_q    <= '0;
            base_q   <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
        end else if (Enable) begin
            state_q  <= state_d;
            rdaddr_q <= rdaddr_d;
            txdata_q <= txdata_d;
            xmitgo_q <= xmitgo_d;
            done_q   <= done_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            base_q   <= base_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
        end
    end

    assign RdAddr = rdaddr_q;
    assign TxData = txdata_q;
    assign XMitGo = xmitgo_q;
    assign Done   = done_q;
    assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer. Stimulus pushes the characters
// and Done pulses a message should produce; a negedge monitor pops and
// compares whenever the DUT strobes XMitGo or Done. The bench also models
// the message memory and a transmitter with randomised busy time.
module tb_uart_msg_sequencer;

    localparam int GAP = 5;

    typedef struct packed {
        logic       is_done;
        logic [7:0] addr;
        logic [7:0] data;
        logic       busy;
    } ev_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] MsgBase = '0;
    logic [7:0] MsgLen = '0;
    logic       TxEmpty = 1'b1;
    logic [7:0] RdData;
    logic [7:0] RdAddr;
    logic       XMitGo;
    logic [7:0] TxData;
    logic       Busy;
    logic       Done;

    logic [7:0] mem [256];
    logic [7:0] rd_q = '0;
    ev_t        exp_q[$];

    int  tests = 0, fails = 0;
    int  xmit_cnt = 0, done_cnt = 0, since_done = 0, tx_busy = 0, en_ph = 0;
    bit  after_done = 0, gap_chk = 0, fast_tx = 1, hold_low = 0, en_toggle = 0;

    uart_msg_sequencer #(.DATA_W(8), .ADDR_W(8), .GAP_CYCLES(GAP)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Start(Start), .Abort(Abort),
        .Mode(Mode), .MsgBase(MsgBase), .MsgLen(MsgLen), .TxEmpty(TxEmpty),
        .RdData(RdData), .RdAddr(RdAddr), .XMitGo(XMitGo), .TxData(TxData),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read message memory, advancing only on enabled edges.
    always @(posedge Clk) if (Enable) rd_q <= mem[RdAddr];
    assign RdData = rd_q;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Enable generator: free-running, or one enabled cycle in four.
    initial forever begin
        @(posedge Clk); #2;
        if (en_toggle) begin
            en_ph  = (en_ph + 1) % 4;
            Enable = (en_ph == 0);
        end else begin
            Enable = 1'b1;
        end
    end

    // Monitor + transmitter model. Sampled at negedge; Enable here is the
    // enable of the coming edge, so a held strobe is counted exactly once.
    initial forever begin
        ev_t ev;
        @(negedge Clk);
        if (!Reset && Enable) begin
            since_done++;
            if (XMitGo) begin
                xmit_cnt++;
                if (gap_chk && after_done) check("gap_len", since_done, GAP + 3);
                after_done = 0;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_xmit: got addr %0h data %0h expected none", RdAddr, TxData);
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_kind_char", 0, ev.is_done);
                    check("char_addr", RdAddr, ev.addr);
                    check("char_data", TxData, ev.data);
                    check("busy_at_char", Busy, ev.busy);
                end
            end
            if (Done) begin
                done_cnt++;
                since_done = 0;
                after_done = 1;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got Done=1 expected none");
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_kind_done", 1, ev.is_done);
                    check("busy_at_done", Busy, ev.busy);
                end
            end
        end
        if (Enable) begin
            if (XMitGo)           tx_busy = fast_tx ? 1 : $urandom_range(1, 6);
            else if (tx_busy > 0) tx_busy--;
        end
        TxEmpty = (tx_busy == 0) && !hold_low;
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    // Expected events for one pass: nchars characters, optional Done.
    task automatic push_pass(logic [7:0] b, int nchars, bit with_done, bit m);
        for (int i = 0; i < nchars; i++) begin
            logic [7:0] a;
            a = b + 8'(i);
            exp_q.push_back('{is_done: 1'b0, addr: a, data: mem[a], busy: 1'b1});
        end
        if (with_done) exp_q.push_back('{is_done: 1'b1, addr: 8'h0, data: 8'h0, busy: m});
    endtask

    // Hold Start until an enabled edge consumes it, then scramble the
    // inputs to prove only the latched copies matter.
    task automatic start_msg(logic [7:0] b, logic [7:0] l, bit m);
        bit e;
        after_done = 0;
        MsgBase = b; MsgLen = l; Mode = m; Start = 1'b1;
        do begin @(posedge Clk); e = Enable; #1; end while (!e);
        Start = 1'b0;
        MsgBase = 8'($urandom); MsgLen = 8'($urandom); Mode = 1'($urandom);
    endtask

    task automatic wait_drain(string name, int budget);
        int k = 0;
        while ((exp_q.size() != 0 || Busy) && k < budget) begin tick(1); k++; end
        check(name, (k < budget), 1);
    endtask

    task automatic wait_done(int target, int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin tick(1); k++; end
        check("wait_done_timeout", (k < budget), 1);
    endtask

    initial begin
        int x0, d0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset state
        tick(3);
        Reset = 1'b0;
        check("rst_rdaddr", RdAddr, 0);
        check("rst_txdata", TxData, 0);
        check("rst_xmitgo", XMitGo, 0);
        check("rst_done", Done, 0);
        check("rst_busy", Busy, 0);

        // One-shot, transmitter always ready
        x0 = xmit_cnt; d0 = done_cnt;
        push_pass(8'h10, 3, 1, 0);
        start_msg(8'h10, 8'd3, 0);
        wait_drain("oneshot_drain", 200);
        check("oneshot_chars", xmit_cnt - x0, 3);
        check("oneshot_dones", done_cnt - d0, 1);
        check("oneshot_busy", Busy, 0);

        // Back-pressure: TxEmpty held low for 20 cycles
        hold_low = 1; tick(1);
        x0 = xmit_cnt;
        push_pass(8'h40, 2, 1, 0);
        start_msg(8'h40, 8'd2, 0);
        tick(20);
        check("bp_no_strobe", xmit_cnt - x0, 0);
        hold_low = 0;
        wait_drain("bp_drain", 200);

        // Address wrap 0xFE -> 0x01
        push_pass(8'hFE, 4, 1, 0);
        start_msg(8'hFE, 8'd4, 0);
        wait_drain("wrap_drain", 200);

        // Zero-length message: Done only
        x0 = xmit_cnt; d0 = done_cnt;
        push_pass(8'h00, 0, 1, 0);
        start_msg(8'h33, 8'd0, 0);
        tick(10);
        check("len0_done", done_cnt - d0, 1);
        check("len0_chars", xmit_cnt - x0, 0);
        check("len0_busy", Busy, 0);

        // Repeat: three passes with exact gap timing, then abort in GAP
        gap_chk = 1;
        d0 = done_cnt;
        for (int p = 0; p < 3; p++) push_pass(8'h20, 2, 1, 1);
        start_msg(8'h20, 8'd2, 1);
        wait_done(d0 + 3, 400);
        Abort = 1; tick(1); Abort = 0;
        check("rep_abort_busy", Busy, 0);
        tick(30);
        check("rep_queue_empty", exp_q.size(), 0);
        gap_chk = 0;

        // Abort after the 2nd strobe of 8, with a Start in the same cycle
        fast_tx = 0;
        x0 = xmit_cnt; d0 = done_cnt;
        push_pass(8'h80, 2, 0, 0);
        start_msg(8'h80, 8'd8, 0);
        begin
            int k = 0;
            while (xmit_cnt - x0 < 2 && k < 300) begin tick(1); k++; end
            check("abort_wait_timeout", (k < 300), 1);
        end
        Abort = 1; Start = 1; MsgLen = 8'd0;
        tick(1);
        Abort = 0; Start = 0;
        check("abort_busy", Busy, 0);
        tick(40);
        check("abort_no_chars", xmit_cnt - x0, 2);
        check("abort_no_done", done_cnt - d0, 0);
        // Abort beats Start in IDLE
        MsgLen = 8'd5; Abort = 1; Start = 1;
        tick(1);
        Abort = 0; Start = 0;
        check("abort_vs_start_busy", Busy, 0);
        tick(20);
        check("abort_vs_start_chars", xmit_cnt - x0, 2);

        // Randomised one-shots, some with enable toggling
        for (int it = 0; it < 12; it++) begin
            logic [7:0] b, l;
            b = 8'($urandom);
            l = 8'($urandom_range(0, 6));
            en_toggle = (it >= 8);
            push_pass(b, int'(l), 1, 0);
            start_msg(b, l, 0);
            if (l >= 3) begin
                tick(2);
                // Ignored Start while busy
                MsgBase = 8'($urandom); MsgLen = 8'd7; Mode = 1; Start = 1;
                tick(1);
                Start = 0;
            end
            wait_drain("rand_drain", 3000);
        end

        // Enable 1:3, repeat, reset mid-GAP on a disabled edge
        en_toggle = 1; fast_tx = 1; tx_busy = 0;
        tick(8);
        gap_chk = 1;
        d0 = done_cnt;
        push_pass(8'h30, 2, 1, 1);
        push_pass(8'h30, 2, 1, 1);
        start_msg(8'h30, 8'd2, 1);
        wait_done(d0 + 2, 2000);
        tick(8);
        check("gap_still_busy", Busy, 1);
        begin
            int k = 0;
            do begin @(posedge Clk); #3; k++; end while (Enable && k < 20);
        end
        Reset = 1;
        @(posedge Clk); #1;
        Reset = 0;
        check("mrst_rdaddr", RdAddr, 0);
        check("mrst_txdata", TxData, 0);
        check("mrst_xmitgo", XMitGo, 0);
        check("mrst_done", Done, 0);
        check("mrst_busy", Busy, 0);
        x0 = xmit_cnt; d0 = done_cnt;
        tick(100);
        check("mrst_quiet_chars", xmit_cnt - x0, 0);
        check("mrst_quiet_done", done_cnt - d0, 0);
        check("final_queue_empty", exp_q.size(), 0);
        en_toggle = 0; gap_chk = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
